// File: rtl/game_flow_sequencer.sv
// Frame-synchronous game screen/state controller; commits screen changes only at end-of-frame.
// Optional fade-in on every transition when SCREEN_FADE_EN is defined (else fade_level is fixed at 15).
module game_flow_sequencer #(
  parameter int FRAME_Y      = 481,
  parameter int DWELL_FRAMES = 120,
  parameter int FADE_STEP    = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        game_start,
  input  logic        pause,
  input  logic        win,
  input  logic        game_over,
  output logic [1:0]  screen_sel,
  output logic        game_freeze,
  output logic        game_clear,
  output logic        frame_tick,
  output logic [1:0]  frame_counter,
  output logic [27:0] frame_count,
  output logic [3:0]  fade_level
);

  localparam logic [1:0] TITLE   = 2'b00;
  localparam logic [1:0] PLAYING = 2'b01;
  localparam logic [1:0] WIN     = 2'b10;
  localparam logic [1:0] OVER    = 2'b11;

  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES);

  logic [1:0]    state, next_state;
  logic          start_meta, game_start_s;
  logic          pause_meta, pause_s;
  logic          pending_win, pending_over;
  logic [DW-1:0] dwell;
  logic          frame_end;
  logic          commit;
  logic          win_any, over_any;

  assign screen_sel = state;
  assign frame_end  = p_tick && (y == 10'(FRAME_Y)) && (x == 10'd0);
  assign win_any    = pending_win  || win;
  assign over_any   = pending_over || game_over;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      start_meta   <= 1'b0;
      game_start_s <= 1'b0;
      pause_meta   <= 1'b0;
      pause_s      <= 1'b0;
    end else begin
      start_meta   <= game_start;
      game_start_s <= start_meta;
      pause_meta   <= pause;
      pause_s      <= pause_meta;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TITLE: begin
        if (game_start_s) next_state = PLAYING;
      end
      PLAYING: begin
        // Win outranks loss and abort when they land on the same commit edge.
        if (win_any)            next_state = WIN;
        else if (over_any)      next_state = OVER;
        else if (!game_start_s) next_state = TITLE;
      end
      default: begin
        if ((dwell >= DWELL_MAX) && !game_start_s) next_state = TITLE;
      end
    endcase
  end

  assign commit = frame_end && (next_state != state);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state        <= TITLE;
      game_freeze  <= 1'b1;
      game_clear   <= 1'b0;
      frame_tick   <= 1'b0;
      pending_win  <= 1'b0;
      pending_over <= 1'b0;
      dwell        <= '0;
    end else begin
      frame_tick <= frame_end;
      game_clear <= commit && (next_state == PLAYING);
      if (commit) begin
        state       <= next_state;
        game_freeze <= (next_state != PLAYING) || pause_s;
      end else begin
        game_freeze <= (state != PLAYING) || pause_s;
      end

      if (commit) begin
        pending_win  <= 1'b0;
        pending_over <= 1'b0;
      end else if (state == PLAYING) begin
        pending_win  <= pending_win  || win;
        pending_over <= pending_over || game_over;
      end

      if (commit && ((next_state == WIN) || (next_state == OVER))) begin
        dwell <= '0;
      end else if (frame_end && ((state == WIN) || (state == OVER)) && (dwell < DWELL_MAX)) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_counter <= 2'd0;
      frame_count   <= 28'd0;
    end else begin
      frame_count <= frame_count + 28'd1;
      if (frame_end) frame_counter <= frame_counter + 2'd1;
    end
  end

`ifdef SCREEN_FADE_EN
  localparam int FW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_STEP - 1);

  logic [FW-1:0] fade_div;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      fade_level <= 4'hF;
      fade_div   <= '0;
    end else if (commit) begin
      fade_level <= 4'h0;
      fade_div   <= '0;
    end else if (frame_end) begin
      if (fade_div == FADE_LAST) begin
        fade_div <= '0;
        if (fade_level != 4'hF) fade_level <= fade_level + 4'h1;
      end else begin
        fade_div <= fade_div + 1'b1;
      end
    end
  end
`else
  assign fade_level = 4'hF;
`endif

endmodule
